// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg_scan_pkg;
  localparam int SEG_W = 7;

  typedef enum logic [1:0] {IDLE, DRIVE, DARK, GAP} scan_state_e;

  // Number of lit cycles contributed by each brightness code step.
  function automatic int calc_step(input int freq, input int bbits);
    return (freq + 1) >> bbits;
  endfunction
endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter and digit index; classifies the upcoming cycle as drive or gap
// so the scan FSM can register its next state without extra latency.
module seg_slot_timer import seg_scan_pkg::*; #(
  parameter int NDIG  = 4,
  parameter int FREQ  = 250,
  parameter int CBITS = 8,
  parameter int BBITS = 3,
  localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [BBITS-1:0] bright_nxt_i,
  output logic [DW-1:0]    dig_o,
  output logic             drv_nxt_o,
  output logic             gap_nxt_o,
  output logic             last_o
);
  localparam int PW                 = CBITS + BBITS;
  localparam logic [CBITS-1:0] CMAX = CBITS'(FREQ);
  localparam logic [DW-1:0]    DMAX = DW'(NDIG - 1);
  localparam logic [BBITS-1:0] BFULL = '1;
  localparam logic [PW-1:0]    STEP_W = PW'(calc_step(FREQ, BBITS));

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic [PW-1:0]    on_len;

  always_comb begin
    cnt_d = cnt_q;
    dig_d = dig_q;
    if (clr_i) begin
      cnt_d = '0;
      dig_d = '0;
    end else if (adv_i) begin
      if (cnt_q == CMAX) begin
        cnt_d = '0;
        dig_d = (dig_q == DMAX) ? '0 : dig_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Full-width product so the lit window never wraps.
  assign on_len    = PW'(bright_nxt_i) * STEP_W;
  assign gap_nxt_o = (cnt_d == CMAX);
  assign drv_nxt_o = (cnt_d < CMAX) && ((bright_nxt_i == BFULL) || (PW'(cnt_d) < on_len));
  assign last_o    = (cnt_q == CMAX) && (dig_q == DMAX);
  assign dig_o     = dig_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      dig_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan scheduler: double-buffered digit load, per-digit
// mask, frame-level PWM brightness, registered segment/digit drive.
module seg_scan_ctrl import seg_scan_pkg::*; #(
  parameter int NDIG  = 4,
  parameter int FREQ  = 250,
  parameter int CBITS = 8,
  parameter int BBITS = 3,
  localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEG_W*NDIG-1:0] in_data,
  input  logic [NDIG-1:0]       in_mask,
  input  logic [BBITS-1:0]      bright,
  output logic [SEG_W-1:0]      segment,
  output logic [NDIG-1:0]       digit_en,
  output logic                  frame_done
);
  scan_state_e state_q, state_d;

  logic [NDIG-1:0][SEG_W-1:0] data_q, pend_data_q;
  logic [NDIG-1:0]            mask_q, pend_mask_q;
  logic [BBITS-1:0]           bright_q, bright_nxt;
  logic                       pend_full_q, pend_full_d, in_ready_q;
  logic [SEG_W-1:0]           seg_q, seg_d;
  logic [NDIG-1:0]            den_q, den_d;
  logic                       fd_q;
  logic [DW-1:0]              dig;
  logic                       drv_nxt, gap_nxt, last;
  logic                       accept, boundary, xfer;

  assign accept     = in_valid && in_ready_q;
  assign boundary   = en && (state_q == GAP) && last;
  // Buffer swap only between frames, or whenever scanning is stopped.
  assign xfer       = pend_full_q && (boundary || !en);
  assign bright_nxt = boundary ? bright : bright_q;

  seg_slot_timer #(
    .NDIG(NDIG), .FREQ(FREQ), .CBITS(CBITS), .BBITS(BBITS)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (!en),
    .adv_i        (en && (state_q != IDLE)),
    .bright_nxt_i (bright_nxt),
    .dig_o        (dig),
    .drv_nxt_o    (drv_nxt),
    .gap_nxt_o    (gap_nxt),
    .last_o       (last)
  );

  always_comb begin
    state_d = IDLE;
    if (en) begin
      if (gap_nxt)      state_d = GAP;
      else if (drv_nxt) state_d = DRIVE;
      else              state_d = DARK;
    end
  end

  always_comb begin
    pend_full_d = pend_full_q;
    if (xfer)   pend_full_d = 1'b0;
    if (accept) pend_full_d = 1'b1;
  end

  // Gated by en so a stop blanks the pins on the very next cycle.
  always_comb begin
    seg_d = '0;
    den_d = '0;
    if (en && (state_q == DRIVE)) begin
      den_d = mask_q & (NDIG'(1) << dig);
      if (mask_q[dig]) seg_d = data_q[dig];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      mask_q      <= '0;
      bright_q    <= '0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
      pend_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
      seg_q       <= '0;
      den_q       <= '0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      in_ready_q  <= !pend_full_d;
      seg_q       <= seg_d;
      den_q       <= den_d;
      fd_q        <= boundary;
      bright_q    <= bright_nxt;
      if (xfer) begin
        data_q <= pend_data_q;
        mask_q <= pend_mask_q;
      end
      if (accept) begin
        pend_data_q <= in_data;
        pend_mask_q <= in_mask;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign segment    = seg_q;
  assign digit_en   = den_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;
  localparam int NDIG  = 2;
  localparam int FREQ  = 7;
  localparam int CBITS = 3;
  localparam int BBITS = 2;
  localparam int STEP  = (FREQ + 1) >> BBITS;
  localparam int TOT   = NDIG * (FREQ + 1);
  localparam int BMAX  = (1 << BBITS) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en = 1'b0, in_valid = 1'b0;
  logic                in_ready;
  logic [7*NDIG-1:0]   in_data = '0;
  logic [NDIG-1:0]     in_mask = '0;
  logic [BBITS-1:0]    bright = '0;
  logic [6:0]          segment;
  logic [NDIG-1:0]     digit_en;
  logic                frame_done;

  int n_chk = 0, n_fail = 0;

  // reference model state
  bit                run, pend, rdy;
  int                p, br;
  logic [7*NDIG-1:0] a_data, p_data;
  logic [NDIG-1:0]   a_mask, p_mask;
  logic [6:0]        e_seg;
  logic [NDIG-1:0]   e_den;
  bit                e_fd;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(NDIG), .FREQ(FREQ), .CBITS(CBITS), .BBITS(BBITS)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .bright(bright),
    .segment(segment), .digit_en(digit_en), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    run = 0; pend = 0; rdy = 0; p = 0; br = 0;
    a_data = '0; p_data = '0; a_mask = '0; p_mask = '0;
    e_seg = '0; e_den = '0; e_fd = 0;
  endtask

  // One clock: frame position p -> (digit, cycle in slot) by plain arithmetic.
  task automatic model_step();
    int c, d;
    bit bnd, acc, xf;
    c = p % (FREQ + 1);
    d = p / (FREQ + 1);
    bnd = run && en && (p == TOT - 1);
    e_seg = '0; e_den = '0; e_fd = bnd;
    if (run && en && (c < FREQ) && (br == BMAX || c < br * STEP) && a_mask[d]) begin
      e_den[d] = 1'b1;
      e_seg = 7'(a_data >> (7 * d));
    end
    acc = in_valid && rdy;
    xf  = pend && (!en || bnd);
    if (xf) begin a_data = p_data; a_mask = p_mask; pend = 0; end
    if (acc) begin p_data = in_data; p_mask = in_mask; pend = 1; end
    if (bnd) br = int'(bright);
    if (en) begin p = run ? (p + 1) % TOT : 0; run = 1; end
    else begin p = 0; run = 0; end
    rdy = !pend;
  endtask

  task automatic check_all();
    chk("segment",    32'(segment),    32'(e_seg));
    chk("digit_en",   32'(digit_en),   32'(e_den));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("in_ready",   32'(in_ready),   32'(rdy));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input logic [7*NDIG-1:0] dat, input logic [NDIG-1:0] msk);
    bit done;
    done = 0;
    in_valid = 1'b1; in_data = dat; in_mask = msk;
    for (int i = 0; i < 100 && !done; i++) begin
      done = rdy;
      cycle();
    end
    in_valid = 1'b0;
    chk("load_timeout", 32'(done), 32'd1);
  endtask

  task automatic rand_run(input int n, input int en_pct, input int vld_pct);
    for (int i = 0; i < n; i++) begin
      en       = ($urandom_range(99) < en_pct);
      in_valid = ($urandom_range(99) < vld_pct);
      in_data  = 14'($urandom);
      in_mask  = 2'($urandom);
      if ($urandom_range(99) < 5) bright = 2'($urandom);
      cycle();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    bit hit;
    model_reset();
    @(negedge clk); check_all();
    @(negedge clk); check_all();
    rst = 1'b1;
    // idle-data frames with scanning on
    en = 1'b1; bright = 2'd3;
    run_n(40);
    // full brightness, both digits
    load(14'h3F06, 2'b11);
    run_n(50);
    // partial and zero brightness
    bright = 2'd1; run_n(40);
    bright = 2'd0; run_n(40);
    // digit 0 masked
    bright = 2'd3;
    load(14'h1A5B, 2'b10);
    run_n(40);
    // back-to-back loads: second one waits for the frame boundary
    load(14'h0C33, 2'b11);
    load(14'h2255, 2'b01);
    run_n(50);
    // stop mid-slot with a pending buffer, then restart
    load(14'h3F06, 2'b11);
    run_n(11);
    en = 1'b0; run_n(4);
    en = 1'b1; run_n(40);
    // random traffic
    rand_run(1500, 97, 30);
    rand_run(500, 70, 40);
    // async reset while a digit is lit
    en = 1'b1; bright = 2'd3;
    load(14'h3F06, 2'b11);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycle();
      hit = (e_den != '0);
    end
    chk("drive_seen", 32'(hit), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_segment",  32'(segment),    32'd0);
    chk("arst_digit_en", 32'(digit_en),   32'd0);
    chk("arst_in_ready", 32'(in_ready),   32'd0);
    chk("arst_fd",       32'(frame_done), 32'd0);
    model_reset();
    run_n(2);
    rst = 1'b1;
    run_n(40);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
